cdb_arbiter: RTL and testbench

Downstream of the reservation-station dispatch stage and the functional units. Collects completed results from FU_NUM functional units and buffers them in per-FU FIFOs. Round-robin arbitrates up to CDB_LANES broadcasts per cycle onto the common data bus (CDB). The CDB is consumed by the reservation stations, the register status table and the ROB.

---
 rtl/cdb_pkg.sv | 27 ++
 rtl/cdb_result_fifo.sv | 54 +++++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB payload type and widths for the result broadcast arbiter.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package cdb_pkg;

  localparam int unsigned PREG_W = `PHYSICAL_REG_NUM_WIDTH;
  localparam int unsigned VAL_W  = `REG_VAL_WIDTH;
  localparam int unsigned TAG_W  = `ROB_SIZE_WIDTH;

  // Lane count of the common data bus, also the CDB interface width.
  localparam int unsigned CDB_LANE_NUM = 2;

  typedef struct packed {
    logic [PREG_W-1:0] dst_reg_addr;
    logic [VAL_W-1:0]  value;
    logic [TAG_W-1:0]  inst_tag;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result FIFO; caller guarantees no push when full and no pop when empty.
module cdb_result_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  cdb_entry_t din_i,
  output cdb_entry_t head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cdb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers FU results and round-robin broadcasts up to CDB_LANES per cycle on the CDB.
// Optional CDB_BYPASS_EN: an empty-FIFO FU with valid input may broadcast in the same cycle.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned FU_NUM     = 4,
  parameter int unsigned CDB_LANES  = CDB_LANE_NUM,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [FU_NUM-1:0]                 fu_valid,
  output logic [FU_NUM-1:0]                 fu_ready,
  input  logic [FU_NUM-1:0][PREG_W-1:0]     fu_dst_reg_addr,
  input  logic [FU_NUM-1:0][VAL_W-1:0]      fu_result,
  input  logic [FU_NUM-1:0][TAG_W-1:0]      fu_inst_tag,
  input  logic                              cdb_ready,
  output logic [CDB_LANES-1:0]              cdb_valid,
  output logic [CDB_LANES-1:0][PREG_W-1:0]  cdb_register_addr,
  output logic [CDB_LANES-1:0][VAL_W-1:0]   cdb_register_val,
  output logic [CDB_LANES-1:0][TAG_W-1:0]   cdb_inst_tag
);

  localparam int unsigned IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  cdb_entry_t [FU_NUM-1:0]    fu_in, head;
  logic [FU_NUM-1:0]          empty, full, cand, grant, pop, push, bypass;
  logic [CDB_LANES-1:0]       lane_valid;
  logic [CDB_LANES-1:0][IDX_W-1:0] lane_src;
  cdb_entry_t [CDB_LANES-1:0] lane_data;
  cdb_entry_t [CDB_LANES-1:0] cdb_q, cdb_d;
  logic [CDB_LANES-1:0]       cdb_valid_q, cdb_valid_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d, last_gnt;

  for (genvar i = 0; i < FU_NUM; i++) begin : g_fu
    assign fu_in[i] = {fu_dst_reg_addr[i], fu_result[i], fu_inst_tag[i]};

    cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   (fu_in[i]),
      .head_o  (head[i]),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );
  end

`ifdef CDB_BYPASS_EN
  assign cand   = ~empty | fu_valid;
  assign bypass = grant & empty & {FU_NUM{cdb_ready}};
`else
  assign cand   = ~empty;
  assign bypass = '0;
`endif

  assign fu_ready = ~full;
  assign pop      = grant & ~empty & {FU_NUM{cdb_ready}};
  assign push     = fu_valid & ~full & ~bypass;

  // Scan from rr_ptr; the n-th candidate found lands on lane n.
  always_comb begin
    int unsigned      n;
    logic [IDX_W-1:0] idx;
    grant      = '0;
    lane_valid = '0;
    lane_src   = '0;
    last_gnt   = rr_ptr_q;
    n          = 0;
    idx        = '0;
    for (int unsigned j = 0; j < FU_NUM; j++) begin
      idx = IDX_W'((32'(rr_ptr_q) + j) % FU_NUM);
      if (cand[idx] && (n < CDB_LANES)) begin
        grant[idx] = 1'b1;
        last_gnt   = idx;
        for (int unsigned k = 0; k < CDB_LANES; k++) begin
          if (n == k) begin
            lane_valid[k] = 1'b1;
            lane_src[k]   = idx;
          end
        end
        n = n + 1;
      end
    end
  end

  always_comb begin
    lane_data = '0;
    for (int unsigned k = 0; k < CDB_LANES; k++) begin
      lane_data[k] = empty[lane_src[k]] ? fu_in[lane_src[k]] : head[lane_src[k]];
    end
  end

  // Unused lanes keep their old data; only the valid bit drops.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_d       = cdb_q;
    rr_ptr_d    = rr_ptr_q;
    if (cdb_ready) begin
      cdb_valid_d = lane_valid;
      for (int unsigned k = 0; k < CDB_LANES; k++) begin
        if (lane_valid[k]) cdb_d[k] = lane_data[k];
      end
      if (|lane_valid) rr_ptr_d = IDX_W'((32'(last_gnt) + 32'd1) % FU_NUM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid_q <= '0;
      cdb_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  for (genvar k = 0; k < CDB_LANES; k++) begin : g_lane
    assign cdb_register_addr[k] = cdb_q[k].dst_reg_addr;
    assign cdb_register_val[k]  = cdb_q[k].value;
    assign cdb_inst_tag[k]      = cdb_q[k].inst_tag;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle vector table with per-FU scoreboards, plus hand sequences.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned FU_NUM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance: 2 lanes
  logic [FU_NUM-1:0]             fu_valid, fu_ready;
  logic [FU_NUM-1:0][PREG_W-1:0] fu_dst;
  logic [FU_NUM-1:0][VAL_W-1:0]  fu_val;
  logic [FU_NUM-1:0][TAG_W-1:0]  fu_tag;
  logic                          cdb_ready;
  logic [1:0]                    cdb_valid;
  logic [1:0][PREG_W-1:0]        cdb_addr;
  logic [1:0][VAL_W-1:0]         cdb_val;
  logic [1:0][TAG_W-1:0]         cdb_tag;

  // Second instance: 1 lane, for the fairness sequence
  logic [FU_NUM-1:0]             fu_valid1, fu_ready1;
  logic [FU_NUM-1:0][PREG_W-1:0] fu_dst1;
  logic [FU_NUM-1:0][VAL_W-1:0]  fu_val1;
  logic [FU_NUM-1:0][TAG_W-1:0]  fu_tag1;
  logic                          cdb_ready1;
  logic [0:0]                    cdb_valid1;
  logic [0:0][PREG_W-1:0]        cdb_addr1;
  logic [0:0][VAL_W-1:0]         cdb_val1;
  logic [0:0][TAG_W-1:0]         cdb_tag1;

  cdb_arbiter #(.FU_NUM(4), .CDB_LANES(2), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_dst_reg_addr(fu_dst), .fu_result(fu_val), .fu_inst_tag(fu_tag),
    .cdb_ready(cdb_ready), .cdb_valid(cdb_valid),
    .cdb_register_addr(cdb_addr), .cdb_register_val(cdb_val), .cdb_inst_tag(cdb_tag)
  );

  cdb_arbiter #(.FU_NUM(4), .CDB_LANES(1), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .fu_valid(fu_valid1), .fu_ready(fu_ready1),
    .fu_dst_reg_addr(fu_dst1), .fu_result(fu_val1), .fu_inst_tag(fu_tag1),
    .cdb_ready(cdb_ready1), .cdb_valid(cdb_valid1),
    .cdb_register_addr(cdb_addr1), .cdb_register_val(cdb_val1), .cdb_inst_tag(cdb_tag1)
  );

  typedef struct {
    logic [3:0] v;       // fu_valid before the edge
    int         t;       // tag used for every FU's data this row
    logic       rdy;     // cdb_ready before the edge
    logic [3:0] ex_rdy;  // fu_ready after the edge
    logic [1:0] ex_val;  // cdb_valid after the edge (ignored on stall rows)
    int         f0;      // FU expected on lane 0
    int         f1;      // FU expected on lane 1
  } row_t;

  row_t       tbl [24];
  cdb_entry_t sbq [FU_NUM][$];
  cdb_entry_t sb1 [FU_NUM][$];
  cdb_entry_t pent [2];
  logic [1:0] pval;
  logic [3:0] prdy;
  int total = 0;
  int bad   = 0;

  function automatic cdb_entry_t mk(input int fu, input int t);
    cdb_entry_t e;
    e.dst_reg_addr = PREG_W'(fu * 16 + t);
    e.value        = VAL_W'(32'hC0DE0000 + 32'(fu * 256 + t));
    e.inst_tag     = TAG_W'(t);
    return e;
  endfunction

  function automatic cdb_entry_t lane(input int k);
    cdb_entry_t e;
    e.dst_reg_addr = cdb_addr[k];
    e.value        = cdb_val[k];
    e.inst_tag     = cdb_tag[k];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_data(input int t);
    cdb_entry_t e;
    for (int i = 0; i < FU_NUM; i++) begin
      e = mk(i, t);
      fu_dst[i] = e.dst_reg_addr;
      fu_val[i] = e.value;
      fu_tag[i] = e.inst_tag;
    end
  endtask

  task automatic run_row(input int idx);
    row_t       r;
    logic [1:0] ev;
    int         fu;
    r = tbl[idx];
    drive_data(r.t);
    fu_valid  = r.v;
    cdb_ready = r.rdy;
    for (int i = 0; i < FU_NUM; i++)
      if (r.v[i] && prdy[i]) sbq[i].push_back(mk(i, r.t));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("row%0d fu_ready", idx), 64'(fu_ready), 64'(r.ex_rdy));
    if (r.rdy) begin
      ev = r.ex_val;
      for (int k = 0; k < 2; k++) begin
        if (ev[k]) begin
          fu = (k == 0) ? r.f0 : r.f1;
          if (sbq[fu].size() == 0) begin
            total++;
            bad++;
            $display("FAIL row%0d lane%0d: scoreboard for FU%0d has nothing, got %0h", idx, k, fu,
                     64'(lane(k)));
          end else begin
            pent[k] = sbq[fu].pop_front();
          end
        end
      end
    end else begin
      ev = pval;
    end
    chk($sformatf("row%0d cdb_valid", idx), 64'(cdb_valid), 64'(ev));
    for (int k = 0; k < 2; k++)
      if (ev[k]) chk($sformatf("row%0d lane%0d entry", idx, k), 64'(lane(k)), 64'(pent[k]));
    pval = ev;
    prdy = r.ex_rdy;
  endtask

  initial begin
    cdb_entry_t exp_e, got_e;
    int         tg1 [FU_NUM];
    logic [3:0] acc;
    int         ef;

    reset = 1'b1;
    fu_valid = '0; cdb_ready = 1'b0; fu_dst = '0; fu_val = '0; fu_tag = '0;
    fu_valid1 = '0; cdb_ready1 = 1'b1; fu_dst1 = '0; fu_val1 = '0; fu_tag1 = '0;

    // {v, t, rdy, ex_rdy, ex_val, f0, f1}
    tbl[0]  = '{4'b1001, 1, 1'b1, 4'b1111, 2'b00, 0, 0};  // rr=3 left by the single-result test
    tbl[1]  = '{4'b0000, 0, 1'b1, 4'b1111, 2'b11, 3, 0};  // scan 3,0
    tbl[2]  = '{4'b1000, 2, 1'b1, 4'b1111, 2'b00, 0, 0};
    tbl[3]  = '{4'b0000, 0, 1'b1, 4'b1111, 2'b01, 3, 0};  // rr back to 0
    tbl[4]  = '{4'b1111, 3, 1'b1, 4'b1111, 2'b00, 0, 0};  // all four push
    tbl[5]  = '{4'b0000, 0, 1'b1, 4'b1111, 2'b11, 0, 1};
    tbl[6]  = '{4'b0000, 0, 1'b1, 4'b1111, 2'b11, 2, 3};
    tbl[7]  = '{4'b0000, 0, 1'b1, 4'b1111, 2'b00, 0, 0};
    tbl[8]  = '{4'b0001, 4, 1'b1, 4'b1111, 2'b00, 0, 0};
    tbl[9]  = '{4'b0010, 1, 1'b1, 4'b1111, 2'b01, 0, 0};
    tbl[10] = '{4'b0010, 2, 1'b0, 4'b1101, 2'b00, 0, 0};  // stall: outputs hold
    tbl[11] = '{4'b0010, 3, 1'b0, 4'b1101, 2'b00, 0, 0};
    tbl[12] = '{4'b0010, 3, 1'b0, 4'b1101, 2'b00, 0, 0};
    tbl[13] = '{4'b0010, 3, 1'b0, 4'b1101, 2'b00, 0, 0};
    tbl[14] = '{4'b0010, 3, 1'b1, 4'b1111, 2'b01, 1, 0};  // full + pop: push refused
    tbl[15] = '{4'b0010, 3, 1'b1, 4'b1111, 2'b01, 1, 0};  // push taken, count stays 1
    tbl[16] = '{4'b0000, 0, 1'b1, 4'b1111, 2'b01, 1, 0};
    tbl[17] = '{4'b0001, 6, 1'b1, 4'b1111, 2'b00, 0, 0};
    tbl[18] = '{4'b0111, 5, 1'b1, 4'b1111, 2'b01, 0, 0};  // leaves 3 entries buffered
    tbl[19] = '{4'b0000, 0, 1'b1, 4'b1111, 2'b00, 0, 0};  // after mid-run reset
    tbl[20] = '{4'b0000, 0, 1'b1, 4'b1111, 2'b00, 0, 0};
    tbl[21] = '{4'b1010, 7, 1'b1, 4'b1111, 2'b00, 0, 0};
    tbl[22] = '{4'b0000, 0, 1'b1, 4'b1111, 2'b11, 1, 3};
    tbl[23] = '{4'b0000, 0, 1'b1, 4'b1111, 2'b00, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset fu_ready", 64'(fu_ready), 64'hF);
    chk("reset lane0", 64'(lane(0)), 64'd0);
    chk("reset lane1", 64'(lane(1)), 64'd0);
    reset = 1'b0;

    // Single result from FU2: two edges to broadcast, one accepted cycle valid
    cdb_ready = 1'b1;
    fu_dst[2] = PREG_W'(7); fu_val[2] = 32'hDEADBEEF; fu_tag[2] = TAG_W'(3);
    fu_valid = 4'b0100;
    exp_e.dst_reg_addr = PREG_W'(7); exp_e.value = 32'hDEADBEEF; exp_e.inst_tag = TAG_W'(3);
    @(posedge clk); @(negedge clk);
    fu_valid = '0;
    chk("single edge1 cdb_valid", 64'(cdb_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("single edge2 cdb_valid", 64'(cdb_valid), 64'b01);
    chk("single edge2 lane0", 64'(lane(0)), 64'(exp_e));
    @(posedge clk); @(negedge clk);
    chk("single edge3 cdb_valid", 64'(cdb_valid), 64'd0);

    pval = '0;
    prdy = 4'hF;
    for (int r = 0; r <= 18; r++) run_row(r);

    // Asynchronous reset with entries buffered and a broadcast on the bus
    reset = 1'b1;
    fu_valid = '0;
    #1;
    chk("midreset cdb_valid", 64'(cdb_valid), 64'd0);
    for (int i = 0; i < FU_NUM; i++) sbq[i].delete();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset fu_ready", 64'(fu_ready), 64'hF);
    pval = '0;
    prdy = 4'hF;
    for (int r = 19; r <= 23; r++) run_row(r);

    // One lane, FU0 and FU3 always valid: grants alternate 0,3,0,3
    for (int i = 0; i < FU_NUM; i++) tg1[i] = 0;
    fu_valid1 = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < FU_NUM; i++) begin
        exp_e = mk(i, tg1[i]);
        fu_dst1[i] = exp_e.dst_reg_addr;
        fu_val1[i] = exp_e.value;
        fu_tag1[i] = exp_e.inst_tag;
      end
      acc = fu_valid1 & fu_ready1;
      for (int i = 0; i < FU_NUM; i++)
        if (acc[i]) sb1[i].push_back(mk(i, tg1[i]));
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < FU_NUM; i++)
        if (acc[i]) tg1[i]++;
      if (c == 0) begin
        chk("rr1 first edge valid", 64'(cdb_valid1), 64'd0);
      end else begin
        ef = (c % 2 == 1) ? 0 : 3;
        chk($sformatf("rr1 edge%0d valid", c + 1), 64'(cdb_valid1), 64'd1);
        got_e.dst_reg_addr = cdb_addr1[0];
        got_e.value        = cdb_val1[0];
        got_e.inst_tag     = cdb_tag1[0];
        if (sb1[ef].size() == 0) begin
          total++;
          bad++;
          $display("FAIL rr1 edge%0d: scoreboard for FU%0d has nothing, got %0h", c + 1, ef,
                   64'(got_e));
        end else begin
          chk($sformatf("rr1 edge%0d entry", c + 1), 64'(got_e), 64'(sb1[ef].pop_front()));
        end
      end
    end
    fu_valid1 = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
